// File: rtl/upower_multicycle_ctrl_pkg.sv
// Shared types and constants for the uPower multi-cycle controller: state encodings,
// default opcodes, ALU/mux select codes and the packed control vector.
package upower_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MADDR  = 4'd2,
      S_MRD    = 4'd3,
      S_MWB    = 4'd4,
      S_MWR    = 4'd5,
      S_XEXEC  = 4'd6,
      S_XWB    = 4'd7,
      S_IEXEC  = 4'd8,
      S_IWB    = 4'd9,
      S_BCMP   = 4'd10,
      S_JUMP   = 4'd11,
      S_HALT   = 4'd12
   } state_e;

   localparam logic [5:0] OPC_XO_DEF   = 6'd31;
   localparam logic [5:0] OPC_LWZ_DEF  = 6'd32;
   localparam logic [5:0] OPC_STW_DEF  = 6'd36;
   localparam logic [5:0] OPC_ADDI_DEF = 6'd14;
   localparam logic [5:0] OPC_B_DEF    = 6'd18;
   localparam logic [5:0] OPC_BC_DEF   = 6'd19;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B    = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;
   localparam logic [1:0] SRCB_BOFF = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_BTGT   = 2'd2;

   typedef struct packed {
      logic       ir_write;
      logic       iord;
      logic       mem_req;
      logic       mem_we;
      logic       reg_write;
      logic       mem_to_reg;
      logic       reg_dst_imm;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
   } ctrl_t;

endpackage

// File: rtl/upower_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master = controller, slave = datapath.
// The retired counter only exists when UPOWER_CTRL_PERF_EN is defined.
interface upower_multicycle_ctrl_if;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        alu_zero;
   logic        ir_write;
   logic        iord;
   logic        mem_req;
   logic        mem_we;
   logic        reg_write;
   logic        mem_to_reg;
   logic        reg_dst_imm;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic        pc_write;
   logic        pc_write_cond;
   logic [1:0]  pc_source;
   logic        illegal;
   logic [3:0]  state_o;
`ifdef UPOWER_CTRL_PERF_EN
   logic [31:0] retired;
`endif

   modport master (
      input  opcode, mem_ready, alu_zero,
      output ir_write, iord, mem_req, mem_we, reg_write, mem_to_reg, reg_dst_imm,
             alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, pc_source,
             illegal, state_o
`ifdef UPOWER_CTRL_PERF_EN
      , output retired
`endif
   );

   modport slave (
      output opcode, mem_ready, alu_zero,
      input  ir_write, iord, mem_req, mem_we, reg_write, mem_to_reg, reg_dst_imm,
             alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, pc_source,
             illegal, state_o
`ifdef UPOWER_CTRL_PERF_EN
      , input retired
`endif
   );
endinterface

// File: rtl/upower_multicycle_ctrl_outdec.sv
// Pure combinational Moore decode: state -> control vector. Only FETCH looks at
// mem_ready, so IR and PC load exactly on the cycle the fetch completes.
module upower_ctrl_outdec
   import upower_ctrl_pkg::*;
(
   input  state_e state_i,
   input  logic   mem_ready_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_req   = 1'b1;
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.alu_op    = ALUOP_ADD;
            ctrl_o.pc_source = PCSRC_ALU;
         end
         S_DECODE: ctrl_o.alu_src_b = SRCB_BOFF;
         S_MADDR, S_IEXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         S_MRD: begin
            ctrl_o.mem_req = 1'b1;
            ctrl_o.iord    = 1'b1;
         end
         S_MWB: begin
            ctrl_o.reg_write   = 1'b1;
            ctrl_o.mem_to_reg  = 1'b1;
            ctrl_o.reg_dst_imm = 1'b1;
         end
         S_MWR: begin
            ctrl_o.mem_req = 1'b1;
            ctrl_o.mem_we  = 1'b1;
            ctrl_o.iord    = 1'b1;
         end
         S_XEXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_B;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         S_XWB: ctrl_o.reg_write = 1'b1;
         S_IWB: begin
            ctrl_o.reg_write   = 1'b1;
            ctrl_o.reg_dst_imm = 1'b1;
         end
         S_BCMP: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_src_b     = SRCB_B;
            ctrl_o.alu_op        = ALUOP_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PCSRC_BTGT;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/upower_multicycle_ctrl.sv
// uPower multi-cycle controller: state register, opcode-driven next state, sticky illegal
// flag; memory states hold until mem_ready. UPOWER_CTRL_PERF_EN adds a retired counter.
module upower_multicycle_ctrl
   import upower_ctrl_pkg::*;
#(
   parameter logic [5:0] OPC_XO   = OPC_XO_DEF,
   parameter logic [5:0] OPC_LWZ  = OPC_LWZ_DEF,
   parameter logic [5:0] OPC_STW  = OPC_STW_DEF,
   parameter logic [5:0] OPC_ADDI = OPC_ADDI_DEF,
   parameter logic [5:0] OPC_B    = OPC_B_DEF,
   parameter logic [5:0] OPC_BC   = OPC_BC_DEF
)(
   input  logic                      clk,
   input  logic                      rst_n,
   upower_multicycle_ctrl_if.master  bus
);

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   ctrl_t  ctrl;

   // The branch-taken decision is alu_zero AND pc_write_cond outside this block.
   logic   alu_zero_unused;
   assign alu_zero_unused = bus.alu_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (bus.opcode == OPC_LWZ || bus.opcode == OPC_STW) state_d = S_MADDR;
            else if (bus.opcode == OPC_XO)                      state_d = S_XEXEC;
            else if (bus.opcode == OPC_ADDI)                    state_d = S_IEXEC;
            else if (bus.opcode == OPC_BC)                      state_d = S_BCMP;
            else if (bus.opcode == OPC_B)                       state_d = S_JUMP;
            else begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end
         end
         S_MADDR:  state_d = (bus.opcode == OPC_LWZ) ? S_MRD : S_MWR;
         S_MRD:    if (bus.mem_ready) state_d = S_MWB;
         S_MWR:    if (bus.mem_ready) state_d = S_FETCH;
         S_XEXEC:  state_d = S_XWB;
         S_IEXEC:  state_d = S_IWB;
         S_MWB, S_XWB, S_IWB, S_BCMP, S_JUMP: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   upower_ctrl_outdec u_outdec (
      .state_i     (state_q),
      .mem_ready_i (bus.mem_ready),
      .ctrl_o      (ctrl)
   );

   assign bus.ir_write      = ctrl.ir_write;
   assign bus.iord          = ctrl.iord;
   assign bus.mem_req       = ctrl.mem_req;
   assign bus.mem_we        = ctrl.mem_we;
   assign bus.reg_write     = ctrl.reg_write;
   assign bus.mem_to_reg    = ctrl.mem_to_reg;
   assign bus.reg_dst_imm   = ctrl.reg_dst_imm;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.alu_op        = ctrl.alu_op;
   assign bus.pc_write      = ctrl.pc_write;
   assign bus.pc_write_cond = ctrl.pc_write_cond;
   assign bus.pc_source     = ctrl.pc_source;
   assign bus.illegal       = illegal_q;
   assign bus.state_o       = state_q;

`ifdef UPOWER_CTRL_PERF_EN
   logic [31:0] retired_q, retired_d;

   // Counts returns to FETCH; the reset entry is not a transition and is not counted.
   assign retired_d = (state_d == S_FETCH && state_q != S_FETCH) ? retired_q + 32'd1 : retired_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retired_q <= '0;
      else        retired_q <= retired_d;
   end

   assign bus.retired = retired_q;
`endif

endmodule

// File: tb/tb_upower_multicycle_ctrl.sv
// Directed bench for upower_multicycle_ctrl: walks each instruction class, memory wait
// states, illegal halt and asynchronous reset, checking against hand-computed values.
module tb_upower_multicycle_ctrl;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   upower_multicycle_ctrl_if bus ();

   upower_multicycle_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a zero-wait fetch of 'op' and land in DECODE.
   task automatic fetch(input logic [5:0] op);
      bus.opcode    = op;
      bus.mem_ready = 1'b1;
      #1;
      check("fetch_state", bus.state_o, 4'd0);
      check("fetch_irw", bus.ir_write, 1'b1);
      tick();
      bus.mem_ready = 1'b0;
      check("decode_state", bus.state_o, 4'd1);
   endtask

   initial begin
      n_cmp         = 0;
      n_bad         = 0;
      clk           = 1'b0;
      rst_n         = 1'b0;
      bus.opcode    = 6'd0;
      bus.mem_ready = 1'b0;
      bus.alu_zero  = 1'b0;
      #12;
      check("rst_state", bus.state_o, 4'd0);
      check("rst_illegal", bus.illegal, 1'b0);
      check("rst_mem_req", bus.mem_req, 1'b1);
      check("rst_ir_write", bus.ir_write, 1'b0);
      check("rst_alu_src_b", bus.alu_src_b, 2'd1);

      // ADDI, mem_ready left high into DECODE to show it is ignored there
      rst_n         = 1'b1;
      bus.opcode    = 6'd14;
      bus.mem_ready = 1'b1;
      #1;
      check("f1_ir_write", bus.ir_write, 1'b1);
      check("f1_pc_write", bus.pc_write, 1'b1);
      tick();
      check("addi_s1", bus.state_o, 4'd1);
      check("addi_dec_srcb", bus.alu_src_b, 2'd3);
      check("addi_dec_req", bus.mem_req, 1'b0);
      check("addi_dec_pcw", bus.pc_write, 1'b0);
      bus.mem_ready = 1'b0;
      tick();
      check("addi_s8", bus.state_o, 4'd8);
      check("addi_srcb", bus.alu_src_b, 2'd2);
      check("addi_exec_rw", bus.reg_write, 1'b0);
      tick();
      check("addi_s9", bus.state_o, 4'd9);
      check("addi_wb_rw", bus.reg_write, 1'b1);
      check("addi_wb_dst", bus.reg_dst_imm, 1'b1);
      tick();
      check("addi_s0", bus.state_o, 4'd0);

      // LWZ with three wait cycles in MRD
      fetch(6'd32);
      tick();
      check("lwz_s2", bus.state_o, 4'd2);
      check("lwz_ma_srca", bus.alu_src_a, 1'b1);
      check("lwz_ma_srcb", bus.alu_src_b, 2'd2);
      tick();
      for (int i = 0; i < 3; i++) begin
         check("lwz_wait_s3", bus.state_o, 4'd3);
         check("lwz_wait_req", bus.mem_req, 1'b1);
         check("lwz_wait_iord", bus.iord, 1'b1);
         tick();
      end
      bus.mem_ready = 1'b1;
      #1;
      check("lwz_done_s3", bus.state_o, 4'd3);
      check("lwz_done_req", bus.mem_req, 1'b1);
      check("lwz_done_we", bus.mem_we, 1'b0);
      tick();
      bus.mem_ready = 1'b0;
      check("lwz_s4", bus.state_o, 4'd4);
      check("lwz_m2r", bus.mem_to_reg, 1'b1);
      check("lwz_rw", bus.reg_write, 1'b1);
      tick();
      check("lwz_s0", bus.state_o, 4'd0);

      // STW, zero wait
      fetch(6'd36);
      check("stw_dec_we", bus.mem_we, 1'b0);
      tick();
      check("stw_s2", bus.state_o, 4'd2);
      check("stw_ma_we", bus.mem_we, 1'b0);
      tick();
      check("stw_s5", bus.state_o, 4'd5);
      check("stw_we", bus.mem_we, 1'b1);
      check("stw_iord", bus.iord, 1'b1);
      check("stw_rw", bus.reg_write, 1'b0);
      bus.mem_ready = 1'b1;
      tick();
      check("stw_s0", bus.state_o, 4'd0);
      check("stw_f_we", bus.mem_we, 1'b0);

      // BC with both zero-flag values: controller output must not depend on it
      for (int z = 0; z < 2; z++) begin
         bus.alu_zero = z[0];
         fetch(6'd19);
         tick();
         check("bc_s10", bus.state_o, 4'd10);
         check("bc_pwc", bus.pc_write_cond, 1'b1);
         check("bc_psrc", bus.pc_source, 2'd1);
         check("bc_pw", bus.pc_write, 1'b0);
         check("bc_aluop", bus.alu_op, 2'b01);
         tick();
         check("bc_s0", bus.state_o, 4'd0);
      end

      // B
      fetch(6'd18);
      tick();
      check("b_s11", bus.state_o, 4'd11);
      check("b_pw", bus.pc_write, 1'b1);
      check("b_psrc", bus.pc_source, 2'd2);
      tick();
      check("b_s0", bus.state_o, 4'd0);

      // XO
      fetch(6'd31);
      tick();
      check("xo_s6", bus.state_o, 4'd6);
      check("xo_aluop", bus.alu_op, 2'b10);
      check("xo_srcb", bus.alu_src_b, 2'd0);
      tick();
      check("xo_s7", bus.state_o, 4'd7);
      check("xo_rw", bus.reg_write, 1'b1);
      check("xo_dst", bus.reg_dst_imm, 1'b0);
      check("xo_m2r", bus.mem_to_reg, 1'b0);
      tick();
      check("xo_s0", bus.state_o, 4'd0);
`ifdef UPOWER_CTRL_PERF_EN
      check("retired_7", bus.retired, 32'd7);
`endif

      // Reset in the middle of a store access
      fetch(6'd36);
      tick();
      tick();
      check("rstmid_s5", bus.state_o, 4'd5);
      check("rstmid_we1", bus.mem_we, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rstmid_we0", bus.mem_we, 1'b0);
      check("rstmid_s0", bus.state_o, 4'd0);
`ifdef UPOWER_CTRL_PERF_EN
      check("retired_clr", bus.retired, 32'd0);
`endif
      rst_n = 1'b1;

      // Illegal opcode: halt and hold, mem_ready ignored
      fetch(6'd63);
      check("ill_dec_flag", bus.illegal, 1'b0);
      tick();
      check("ill_s12", bus.state_o, 4'd12);
      check("ill_flag", bus.illegal, 1'b1);
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("ill_hold", bus.state_o, 4'd12);
         check("ill_req", bus.mem_req, 1'b0);
      end
      check("ill_sticky", bus.illegal, 1'b1);
      rst_n = 1'b0;
      #1;
      check("ill_rst_flag", bus.illegal, 1'b0);
      check("ill_rst_s0", bus.state_o, 4'd0);
      rst_n      = 1'b1;
      bus.opcode = 6'd14;
      tick();
      check("restart_s1", bus.state_o, 4'd1);
`ifdef UPOWER_CTRL_PERF_EN
      check("retired_0", bus.retired, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/upower_multicycle_ctrl.md
Name: upower_multicycle_ctrl

Overview:
Multi-cycle control FSM for the uPower core. Sequences the shared ALU, register file, instruction register and unified memory port through fetch/decode/execute/memory/writeback. Drives alu_op[1:0] into the ALU control decoder, which resolves the final ALU function from xox/xoxo. Handles variable-latency memory through a req/ready handshake.

Parameters:
- OPC_XO, default 31: X/XO-type opcode (add, subf, and, or).
- OPC_LWZ, default 32: load word opcode.
- OPC_STW, default 36: store word opcode.
- OPC_ADDI, default 14: add-immediate opcode.
- OPC_B, default 18: unconditional branch opcode.
- OPC_BC, default 19: conditional branch (equal) opcode.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- alu_zero  in  1  ALU zero flag from the BC compare.
- ir_write  out  1  load IR from memory read data.
- iord  out  1  0 = memory address from PC; 1 = from ALUOut.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write enable; only meaningful with mem_req.
- reg_write  out  1  register-file write.
- mem_to_reg  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- reg_dst_imm  out  1  1 = D-form destination field, 0 = X/XO-form destination field.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-extended imm, 3 = shifted branch offset.
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct decode.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by alu_zero (external AND).
- pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = branch target.
- illegal  out  1  sticky; set on unknown opcode.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset (rst_n low, asynchronous): state = FETCH and illegal = 0. All outputs take the FETCH decode. The first cycle after reset release issues a fetch.
- All outputs are a Moore decode of the state register. Unlisted outputs are 0 in each state.
- States and encodings:
  - FETCH(0): mem_req=1, iord=0, ir_write=mem_ready, alu_src_a=0, alu_src_b=1, alu_op=00, pc_write=mem_ready, pc_source=0. Holds until mem_ready, then → DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=3, alu_op=00 (precompute branch target into ALUOut). Next state by opcode:
    - LWZ/STW → MADDR.
    - XO → XEXEC.
    - ADDI → IEXEC.
    - BC → BCMP.
    - B → JUMP.
    - any other opcode → HALT, with illegal set.
  - MADDR(2): alu_src_a=1, alu_src_b=2, alu_op=00. → MRD for LWZ, → MWR for STW.
  - MRD(3): mem_req=1, iord=1. Holds until mem_ready → MWB.
  - MWB(4): reg_write=1, mem_to_reg=1, reg_dst_imm=1. → FETCH.
  - MWR(5): mem_req=1, mem_we=1, iord=1. Holds until mem_ready → FETCH.
  - XEXEC(6): alu_src_a=1, alu_src_b=0, alu_op=10. → XWB.
  - XWB(7): reg_write=1, mem_to_reg=0, reg_dst_imm=0. → FETCH.
  - IEXEC(8): alu_src_a=1, alu_src_b=2, alu_op=00. → IWB.
  - IWB(9): reg_write=1, reg_dst_imm=1. → FETCH.
  - BCMP(10): alu_src_a=1, alu_src_b=0, alu_op=01, pc_write_cond=1, pc_source=1. → FETCH.
  - JUMP(11): pc_write=1, pc_source=2. → FETCH.
  - HALT(12): all outputs 0; remains here until reset.
- Encodings 13–15 are unreachable. If entered, the next state is FETCH.
- Handshake: mem_req and mem_we stay stable while waiting. The access completes on the cycle mem_ready is high with mem_req high. mem_ready outside a request state is ignored.
- Latency per instruction with zero memory wait states:
  - LWZ: 5 cycles.
  - STW: 4 cycles.
  - XO and ADDI: 4 cycles.
  - BC and B: 3 cycles.
  - Each wait cycle adds 1.
- Reset asserted mid-access drops mem_req immediately (asynchronously). No partial write is committed by the controller.

Optional Feature:
- Macro UPOWER_CTRL_PERF_EN.
- When defined:
  - Adds output retired[31:0], an instruction counter.
  - Increments on every transition into FETCH from a state other than FETCH itself; the reset→FETCH entry does not count.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by rst_n.
- When undefined: the port and the counter are absent.

Decomposition:
- Package upower_ctrl_pkg holds:
  - state encodings;
  - opcode constants;
  - alu_op codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10);
  - alu_src_b and pc_source select codes.
- One natural sub-module, upower_ctrl_outdec: purely combinational state→control-vector decode. The top module keeps the state register, next-state logic, illegal flag and perf counter.

Test Plan:
- Reset release, then fetch with mem_ready high on cycle 1 → ir_write=1 and pc_write=1 in that cycle, state_o=1 next cycle.
- ADDI (opcode 14), zero wait → states 0,1,8,9,0; alu_src_b=2 in state 8; reg_write=1 only in IWB.
- LWZ (32) with mem_ready held low for 3 cycles in MRD → mem_req and iord stable for 4 cycles; total 8 cycles; mem_to_reg=1 in MWB.
- STW (36) → mem_we=1 only in MWR; reg_write never asserted.
- BC (19) with alu_zero=0 and then alu_zero=1 → pc_write_cond=1 and pc_source=1 in BCMP both times, pc_write=0 in both.
- Opcode 63 → illegal=1, state 12 held for 10+ cycles; rst_n pulse clears illegal and restarts FETCH. With UPOWER_CTRL_PERF_EN defined, retired counts 1 per completed instruction, and a preload of 0xFFFFFFFF wraps to 0.
